// File: rtl/max_pool_pkg.sv
// Shared definitions for the max-pool backward pass:
//   state_t      - sequencer states
//   ARGMAX_NONE  - argmax value meaning "no element beat +0.0"
//   IDX_*        - field positions inside a 3 x 16-bit index port
//   fp64_gt      - ordered binary64 greater-than (-0.0 == +0.0, NaN unsupported)
package max_pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    GRAD,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned IDX_ENTRY = 2;
  localparam int unsigned IDX_Y     = 1;
  localparam int unsigned IDX_X     = 0;

  localparam logic [7:0] ARGMAX_NONE = 8'hFF;

  // Sign-magnitude compare: magnitudes order like unsigned integers, the
  // order reverses for negatives, and both zeros compare equal.
  function automatic logic fp64_gt(input logic [63:0] a, input logic [63:0] b);
    logic a_zero;
    logic b_zero;
    a_zero = (a[62:0] == '0);
    b_zero = (b[62:0] == '0);
    if (a_zero && b_zero)  return 1'b0;
    if (a[63] != b[63])    return b[63];
    if (a[63] == 1'b0)     return a[62:0] > b[62:0];
    return a[62:0] < b[62:0];
  endfunction

endpackage

// File: rtl/act_memory.sv
// Single-write, single-read memory addressed by (entry, y, x).
//   clk           - clock, rising edge
//   i_write       - write strobe; out-of-range addresses are dropped
//   i_write_data  - write value
//   i_write_index - write address, [2]=entry [1]=y [0]=x
//   i_read_index  - read address, same layout
//   o_read_data   - registered read value (one-cycle latency), 0 when out of range
module act_memory
  import max_pool_pkg::*;
#(
  parameter string       NAME       = "act_memory",
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned DIM        = 26,
  parameter int unsigned DATA_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 i_write,
  input  logic [DATA_SIZE-1:0] i_write_data,
  input  logic [15:0]          i_write_index [3],
  input  logic [15:0]          i_read_index  [3],
  output logic [DATA_SIZE-1:0] o_read_data
);

  localparam int unsigned DEPTH = NUM_INPUTS * DIM * DIM;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH == 0) begin : g_empty
    $fatal(1, "%s: memory has no entries", NAME);
  end

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rdata;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [AW-1:0]        w_wr_addr;
  logic [AW-1:0]        w_rd_addr;

  function automatic logic f_ok(input logic [15:0] e, input logic [15:0] y,
                                input logic [15:0] x);
    return (32'(e) < NUM_INPUTS) && (32'(y) < DIM) && (32'(x) < DIM);
  endfunction

  function automatic logic [AW-1:0] f_addr(input logic [15:0] e, input logic [15:0] y,
                                           input logic [15:0] x);
    int unsigned a;
    a = (32'(e) * DIM + 32'(y)) * DIM + 32'(x);
    return AW'(a);
  endfunction

  always_comb begin
    w_wr_ok   = f_ok(i_write_index[IDX_ENTRY], i_write_index[IDX_Y], i_write_index[IDX_X]);
    w_rd_ok   = f_ok(i_read_index[IDX_ENTRY], i_read_index[IDX_Y], i_read_index[IDX_X]);
    w_wr_addr = f_addr(i_write_index[IDX_ENTRY], i_write_index[IDX_Y], i_write_index[IDX_X]);
    w_rd_addr = f_addr(i_read_index[IDX_ENTRY], i_read_index[IDX_Y], i_read_index[IDX_X]);
  end

  always_ff @(posedge clk) begin
    if (i_write && w_wr_ok) r_mem[w_wr_addr] <= i_write_data;
    r_rdata <= w_rd_ok ? r_mem[w_rd_addr] : '0;
  end

  assign o_read_data = r_rdata;

endmodule

// File: rtl/max_pool_backward.sv
// Max-pool backward pass: routes each upstream gradient to the position of
// its window's (zero-seeded, first-wins) maximum activation.
//   clk, rst_n                        - clock / async active-low reset
//   act_write/_data/_index            - activation memory load (INPUT_DIM grid)
//   grad_write/_data/_index           - upstream gradient load (OUTPUT_DIM grid)
//   read_index / read_data            - result readout, one-cycle latency
//   compute                           - start request (IDLE/DONE only)
//   busy / output_valid               - pass running / pass finished
module max_pool_backward
  import max_pool_pkg::*;
#(
  parameter string       NAME       = "MAXPOOL_BWD_DEFAULT_NAME",
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned INPUT_DIM  = 26,
  parameter int unsigned KERNEL_DIM = 2,
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned STRIDE     = KERNEL_DIM,
  parameter int unsigned OUTPUT_DIM = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 act_write,
  input  logic [DATA_SIZE-1:0] act_write_data,
  input  logic [15:0]          act_write_index [3],
  input  logic                 grad_write,
  input  logic [DATA_SIZE-1:0] grad_write_data,
  input  logic [15:0]          grad_write_index [3],
  input  logic [15:0]          read_index [3],
  output logic [DATA_SIZE-1:0] read_data,
  input  logic                 compute,
  output logic                 busy,
  output logic                 output_valid
);

  localparam int unsigned KK = KERNEL_DIM * KERNEL_DIM;

  if (STRIDE != KERNEL_DIM) begin : g_bad_stride
    $fatal(1, "%s: STRIDE (%0d) must equal KERNEL_DIM (%0d)", NAME, STRIDE, KERNEL_DIM);
  end

  state_t               r_state, w_next;
  logic [15:0]          r_e, r_y, r_x;       // CLEAR walks the input grid, SCAN..WRITE the window grid
  logic [7:0]           r_k, r_rd_k, r_argmax;
  logic                 r_rd_valid;
  logic [DATA_SIZE-1:0] r_best;

  logic                 w_busy, w_clr_last, w_win_last, w_k_last;
  logic [DATA_SIZE-1:0] w_act_rdata, w_grad_rdata;
  logic [15:0]          w_act_rd_idx [3];
  logic [15:0]          w_grad_rd_idx [3];
  logic [15:0]          w_res_wr_idx [3];
  logic                 w_res_we;
  logic [DATA_SIZE-1:0] w_res_wdata;

  assign w_busy     = (r_state == CLEAR) || (r_state == SCAN) || (r_state == GRAD) || (r_state == WRITE);
  assign w_clr_last = (r_e == 16'(NUM_INPUTS - 1)) && (r_y == 16'(INPUT_DIM - 1)) && (r_x == 16'(INPUT_DIM - 1));
  assign w_win_last = (r_e == 16'(NUM_INPUTS - 1)) && (r_y == 16'(OUTPUT_DIM - 1)) && (r_x == 16'(OUTPUT_DIM - 1));
  assign w_k_last   = (r_k == 8'(KK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (compute) w_next = CLEAR;
      CLEAR:   if (w_clr_last) w_next = SCAN;
      SCAN:    if (w_k_last) w_next = GRAD;
      GRAD:    w_next = WRITE;
      WRITE:   w_next = w_win_last ? DONE : SCAN;
      DONE:    if (compute) w_next = CLEAR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_y <= '0;
      r_x <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (compute) begin
          r_e <= '0;
          r_y <= '0;
          r_x <= '0;
          r_k <= '0;
        end
        CLEAR: begin
          if (r_x == 16'(INPUT_DIM - 1)) begin
            r_x <= '0;
            if (r_y == 16'(INPUT_DIM - 1)) begin
              r_y <= '0;
              r_e <= w_clr_last ? '0 : r_e + 16'd1;
            end else begin
              r_y <= r_y + 16'd1;
            end
          end else begin
            r_x <= r_x + 16'd1;
          end
        end
        SCAN: r_k <= w_k_last ? '0 : r_k + 8'd1;
        WRITE: begin
          if (r_x == 16'(OUTPUT_DIM - 1)) begin
            r_x <= '0;
            if (r_y == 16'(OUTPUT_DIM - 1)) begin
              r_y <= '0;
              r_e <= w_win_last ? '0 : r_e + 16'd1;
            end else begin
              r_y <= r_y + 16'd1;
            end
          end else begin
            r_x <= r_x + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Activation data lags its SCAN read by one cycle; r_rd_valid/r_rd_k tag
  // it, so the last element is compared during GRAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_k     <= '0;
      r_best     <= '0;
      r_argmax   <= ARGMAX_NONE;
    end else begin
      r_rd_valid <= (r_state == SCAN);
      r_rd_k     <= r_k;
      if ((r_state == CLEAR) || (r_state == WRITE)) begin
        r_best   <= '0;
        r_argmax <= ARGMAX_NONE;
      end else if (r_rd_valid && fp64_gt(w_act_rdata, r_best)) begin
        r_best   <= w_act_rdata;
        r_argmax <= r_rd_k;
      end
    end
  end

  always_comb begin
    w_act_rd_idx[IDX_ENTRY]  = r_e;
    w_act_rd_idx[IDX_Y]      = 16'(32'(r_y) * STRIDE + 32'(r_k) / KERNEL_DIM);
    w_act_rd_idx[IDX_X]      = 16'(32'(r_x) * STRIDE + 32'(r_k) % KERNEL_DIM);
    w_grad_rd_idx[IDX_ENTRY] = r_e;
    w_grad_rd_idx[IDX_Y]     = r_y;
    w_grad_rd_idx[IDX_X]     = r_x;
  end

  // Result write port: CLEAR zero-fill, or WRITE at the argmax position.
  always_comb begin
    w_res_we                = 1'b0;
    w_res_wdata             = '0;
    w_res_wr_idx[IDX_ENTRY] = r_e;
    w_res_wr_idx[IDX_Y]     = r_y;
    w_res_wr_idx[IDX_X]     = r_x;
    if (r_state == CLEAR) begin
      w_res_we = 1'b1;
    end else if ((r_state == WRITE) && (r_argmax != ARGMAX_NONE)) begin
      w_res_we            = 1'b1;
      w_res_wdata         = w_grad_rdata;
      w_res_wr_idx[IDX_Y] = 16'(32'(r_y) * STRIDE + 32'(r_argmax) / KERNEL_DIM);
      w_res_wr_idx[IDX_X] = 16'(32'(r_x) * STRIDE + 32'(r_argmax) % KERNEL_DIM);
    end
  end

  act_memory #(
    .NAME       ({NAME, "_act"}),
    .NUM_INPUTS (NUM_INPUTS),
    .DIM        (INPUT_DIM),
    .DATA_SIZE  (DATA_SIZE)
  ) u_act_mem (
    .clk           (clk),
    .i_write       (act_write && !w_busy),
    .i_write_data  (act_write_data),
    .i_write_index (act_write_index),
    .i_read_index  (w_act_rd_idx),
    .o_read_data   (w_act_rdata)
  );

  act_memory #(
    .NAME       ({NAME, "_grad"}),
    .NUM_INPUTS (NUM_INPUTS),
    .DIM        (OUTPUT_DIM),
    .DATA_SIZE  (DATA_SIZE)
  ) u_grad_mem (
    .clk           (clk),
    .i_write       (grad_write && !w_busy),
    .i_write_data  (grad_write_data),
    .i_write_index (grad_write_index),
    .i_read_index  (w_grad_rd_idx),
    .o_read_data   (w_grad_rdata)
  );

  act_memory #(
    .NAME       ({NAME, "_res"}),
    .NUM_INPUTS (NUM_INPUTS),
    .DIM        (INPUT_DIM),
    .DATA_SIZE  (DATA_SIZE)
  ) u_res_mem (
    .clk           (clk),
    .i_write       (w_res_we),
    .i_write_data  (w_res_wdata),
    .i_write_index (w_res_wr_idx),
    .i_read_index  (read_index),
    .o_read_data   (read_data)
  );

  assign busy         = w_busy;
  assign output_valid = (r_state == DONE);

endmodule

// File: tb/tb_max_pool_backward.sv
// Two instances (INPUT_DIM 4 and 5, one entry, 2x2 kernel) share all inputs;
// each is compared against a per-location model of the routing rule.
module tb_max_pool_backward;

  localparam int K = 2;
  localparam int N = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, act_write, grad_write, compute;
  logic [63:0] act_write_data, grad_write_data;
  logic [15:0] act_write_index [3];
  logic [15:0] grad_write_index [3];
  logic [15:0] read_index [3];
  logic [63:0] rd4, rd5;
  logic        busy4, busy5, ov4, ov5;

  max_pool_backward #(.NAME("tb_d4"), .NUM_INPUTS(1), .INPUT_DIM(4), .KERNEL_DIM(2), .DATA_SIZE(64)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .act_write(act_write), .act_write_data(act_write_data), .act_write_index(act_write_index),
    .grad_write(grad_write), .grad_write_data(grad_write_data), .grad_write_index(grad_write_index),
    .read_index(read_index), .read_data(rd4),
    .compute(compute), .busy(busy4), .output_valid(ov4));

  max_pool_backward #(.NAME("tb_d5"), .NUM_INPUTS(1), .INPUT_DIM(5), .KERNEL_DIM(2), .DATA_SIZE(64)) u_d5 (
    .clk(clk), .rst_n(rst_n),
    .act_write(act_write), .act_write_data(act_write_data), .act_write_index(act_write_index),
    .grad_write(grad_write), .grad_write_data(grad_write_data), .grad_write_index(grad_write_index),
    .read_index(read_index), .read_data(rd5),
    .compute(compute), .busy(busy5), .output_valid(ov5));

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  t0, lat4, lat5;
  real m_act [5][5];
  real m_grad [2][2];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    real a [4];
    real g;
    real e [4];
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic int lat_exp(input int d);
    int o;
    o = (d - K) / K + 1;
    return N * d * d + N * o * o * (K * K + 2) + 1;
  endfunction

  // Gradient landing at (y,x): the window containing it must exist, and its
  // first strictly-greater-than-+0.0 maximum must be at (y,x).
  function automatic real f_exp(input int d, input int y, input int x);
    int  o, oy, ox, arg;
    real best, v;
    o  = (d - K) / K + 1;
    oy = y / K;
    ox = x / K;
    if (oy >= o || ox >= o) return 0.0;
    best = 0.0;
    arg  = -1;
    for (int k = 0; k < K * K; k++) begin
      v = m_act[oy * K + k / K][ox * K + k % K];
      if (v > best) begin
        best = v;
        arg  = k;
      end
    end
    return (arg == (y % K) * K + (x % K)) ? m_grad[oy][ox] : 0.0;
  endfunction

  task automatic write_act(input int y, input int x, input real v, input bit upd);
    act_write = 1'b1;
    act_write_index[2] = 16'd0;
    act_write_index[1] = 16'(y);
    act_write_index[0] = 16'(x);
    act_write_data = $realtobits(v);
    @(posedge clk);
    #1 act_write = 1'b0;
    if (upd) m_act[y][x] = v;
  endtask

  task automatic write_grad(input int y, input int x, input real v, input bit upd);
    grad_write = 1'b1;
    grad_write_index[2] = 16'd0;
    grad_write_index[1] = 16'(y);
    grad_write_index[0] = 16'(x);
    grad_write_data = $realtobits(v);
    @(posedge clk);
    #1 grad_write = 1'b0;
    if (upd) m_grad[y][x] = v;
  endtask

  // Optional activation write on the same edge as compute; it must land.
  task automatic start_pass(input bit w, input int y, input int x, input real v);
    compute = 1'b1;
    if (w) begin
      act_write = 1'b1;
      act_write_index[2] = 16'd0;
      act_write_index[1] = 16'(y);
      act_write_index[0] = 16'(x);
      act_write_data = $realtobits(v);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    compute = 1'b0;
    act_write = 1'b0;
    if (w) m_act[y][x] = v;
    chk("start_ov_d4", {63'd0, ov4}, 64'd0);
    chk("start_ov_d5", {63'd0, ov5}, 64'd0);
    chk("start_busy_d4", {63'd0, busy4}, 64'd1);
    chk("start_busy_d5", {63'd0, busy5}, 64'd1);
  endtask

  task automatic wait_done();
    lat4 = 0;
    lat5 = 0;
    while ((lat4 == 0 || lat5 == 0) && (cyc - t0) < 300) begin
      @(posedge clk);
      #1;
      if (lat4 == 0 && ov4) lat4 = cyc - t0 + 1;
      if (lat5 == 0 && ov5) lat5 = cyc - t0 + 1;
    end
    chk("latency_d4", 64'(lat4), 64'(lat_exp(4)));
    chk("latency_d5", 64'(lat5), 64'(lat_exp(5)));
    chk("done_busy_d4", {63'd0, busy4}, 64'd0);
    chk("done_busy_d5", {63'd0, busy5}, 64'd0);
  endtask

  task automatic read_at(input int y, input int x);
    read_index[2] = 16'd0;
    read_index[1] = 16'(y);
    read_index[0] = 16'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        read_at(y, x);
        chk($sformatf("%s_d5_y%0dx%0d", tag, y, x), rd5, $realtobits(f_exp(5, y, x)));
        if (y < 4 && x < 4)
          chk($sformatf("%s_d4_y%0dx%0d", tag, y, x), rd4, $realtobits(f_exp(4, y, x)));
      end
    end
  endtask

  task automatic load_base();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        write_act(y, x, (y < 4 && x < 4) ? real'(y * 4 + x + 1) : 100.0, 1'b1);
    write_grad(0, 0, 10.0, 1'b1);
    write_grad(0, 1, 20.0, 1'b1);
    write_grad(1, 0, 30.0, 1'b1);
    write_grad(1, 1, 40.0, 1'b1);
  endtask

  initial begin
    tbl[0] = '{a: '{1.0, 2.0, 3.0, 4.0},    g: 5.0, e: '{0.0, 0.0, 0.0, 5.0}};
    tbl[1] = '{a: '{2.0, 5.0, 5.0, 1.0},    g: 7.0, e: '{0.0, 7.0, 0.0, 0.0}};
    tbl[2] = '{a: '{-1.0, -2.0, -0.0, -3.0}, g: 9.0, e: '{0.0, 0.0, 0.0, 0.0}};
    tbl[3] = '{a: '{0.0, 0.0, 0.0, 0.0},    g: 4.0, e: '{0.0, 0.0, 0.0, 0.0}};
    tbl[4] = '{a: '{6.0, -1.0, 6.0, 6.0},   g: 3.0, e: '{3.0, 0.0, 0.0, 0.0}};
    tbl[5] = '{a: '{0.5, -0.0, 0.25, 0.75}, g: 2.0, e: '{0.0, 0.0, 0.0, 2.0}};

    rst_n = 1'b0;
    act_write = 1'b0;
    grad_write = 1'b0;
    compute = 1'b0;
    act_write_data = '0;
    grad_write_data = '0;
    for (int i = 0; i < 3; i++) begin
      act_write_index[i] = '0;
      grad_write_index[i] = '0;
      read_index[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy_d4", {63'd0, busy4}, 64'd0);
    chk("reset_busy_d5", {63'd0, busy5}, 64'd0);
    chk("reset_ov_d4", {63'd0, ov4}, 64'd0);
    chk("reset_ov_d5", {63'd0, ov5}, 64'd0);

    // Raster activations 1..16, gradients 10..40; uncovered row/col 4 hold 100.0.
    load_base();
    start_pass(1'b0, 0, 0, 0.0);
    wait_done();
    read_at(1, 1); chk("base_11", rd4, $realtobits(10.0));
    read_at(1, 3); chk("base_13", rd4, $realtobits(20.0));
    read_at(3, 1); chk("base_31", rd4, $realtobits(30.0));
    read_at(3, 3); chk("base_33", rd4, $realtobits(40.0));
    read_at(4, 4); chk("base_d5_44", rd5, 64'd0);
    check_all("base");

    // Window (0,0) vectors with hand-derived results.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) write_act(k / 2, k % 2, tbl[i].a[k], 1'b1);
      write_grad(0, 0, tbl[i].g, 1'b1);
      start_pass(1'b0, 0, 0, 0.0);
      wait_done();
      for (int k = 0; k < 4; k++) begin
        read_at(k / 2, k % 2);
        chk($sformatf("tbl%0d_k%0d_d4", i, k), rd4, $realtobits(tbl[i].e[k]));
        chk($sformatf("tbl%0d_k%0d_d5", i, k), rd5, $realtobits(tbl[i].e[k]));
      end
    end

    // Reset during SCAN, then a clean rerun of the base pass.
    load_base();
    start_pass(1'b0, 0, 0, 0.0);
    repeat (20) @(posedge clk);
    #3;
    chk("pre_rst_busy_d4", {63'd0, busy4}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_d4", {63'd0, busy4}, 64'd0);
    chk("rst_busy_d5", {63'd0, busy5}, 64'd0);
    chk("rst_ov_d4", {63'd0, ov4}, 64'd0);
    chk("rst_ov_d5", {63'd0, ov5}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_pass(1'b0, 0, 0, 0.0);
    wait_done();
    check_all("after_rst");

    // Restart from DONE; writes and compute while busy must be ignored.
    start_pass(1'b0, 0, 0, 0.0);
    write_act(0, 0, 99.0, 1'b0);
    write_grad(0, 0, 555.0, 1'b0);
    compute = 1'b1;
    @(posedge clk);
    #1 compute = 1'b0;
    wait_done();
    check_all("busy_wr");

    // Random passes with ties, negatives and zeros; one write shares the compute edge.
    for (int it = 0; it < 4; it++) begin
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          write_act(y, x, real'(int'($urandom_range(0, 8)) - 4) * 0.5, 1'b1);
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++)
          write_grad(y, x, real'($urandom_range(1, 100)), 1'b1);
      start_pass(1'b1, 1, 0, real'($urandom_range(1, 6)));
      wait_done();
      check_all($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_pool_backward.md
MAX_POOL_BACKWARD -- requirements
Module: max_pool_backward

Interface
REQ-001 SHALL have parameter NAME, default "MAXPOOL_BWD_DEFAULT_NAME", debug label for the internal memories.
REQ-002 SHALL have parameter NUM_INPUTS, default 16, the number of channel entries.
REQ-003 SHALL have parameter INPUT_DIM, default 26, the forward input (gradient output) side length.
REQ-004 SHALL have parameter KERNEL_DIM, default 2, the pooling window side.
REQ-005 SHALL have parameter DATA_SIZE, default 64, the IEEE-754 binary64 word width.
REQ-006 SHALL have parameter STRIDE, default KERNEL_DIM; any other value is a fatal elaboration error.
REQ-007 SHALL have parameter OUTPUT_DIM, default (INPUT_DIM-KERNEL_DIM)/STRIDE+1, the upstream gradient side length.
REQ-008 SHALL provide ports as follows; every index port is three unpacked 16-bit fields: [2]=entry, [1]=y, [0]=x.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- act_write  in  1  write strobe, forward activation memory (INPUT_DIM grid)
- act_write_data  in  DATA_SIZE  activation value
- act_write_index  in  16x3  activation write address
- grad_write  in  1  write strobe, upstream gradient memory (OUTPUT_DIM grid)
- grad_write_data  in  DATA_SIZE  upstream gradient value
- grad_write_index  in  16x3  gradient write address
- read_index  in  16x3  read address, result memory (INPUT_DIM grid)
- read_data  out  DATA_SIZE  result gradient, one-cycle synchronous read
- compute  in  1  start request, sampled at clk
- busy  out  1  high from compute acceptance until DONE
- output_valid  out  1  high in DONE

Function
REQ-009 SHALL implement the FSM states IDLE, CLEAR, SCAN, GRAD, WRITE, DONE.
REQ-010 IDLE: compute=1 SHALL move to CLEAR with all counters zeroed and busy=1.
REQ-011 CLEAR SHALL write +0.0 to every result location, one per cycle in raster order (entry, y, x); this takes NUM_INPUTS*INPUT_DIM^2 cycles, then the FSM moves to SCAN.
REQ-012 SCAN SHALL issue KERNEL_DIM^2 activation reads for the current window, k = 0..K^2-1, read at x = ox*STRIDE + k%K, y = oy*STRIDE + k/K.
REQ-013 In SCAN, best SHALL be seeded to +0.0 with argmax=NONE; a read value replaces best and sets argmax=k only if it is strictly greater than best.
REQ-014 A tie SHALL keep the earlier k; a window with no element > +0.0 SHALL have its gradient discarded, matching max_pool's zero-seeded max.
REQ-015 The comparison SHALL be an ordered binary64 compare: -0.0 == +0.0; NaN inputs are unsupported and their result is undefined.
REQ-016 GRAD SHALL read the upstream gradient at (entry, oy, ox) and absorb the final one-cycle activation read latency.
REQ-017 WRITE SHALL, if argmax != NONE, write the gradient to the result at the argmax position; otherwise it writes nothing.
REQ-018 From WRITE, window (ox, oy, entry) SHALL advance with ox wrapping at OUTPUT_DIM into oy, and oy wrapping into entry.
REQ-019 After the last window (NUM_INPUTS-1, OUTPUT_DIM-1, OUTPUT_DIM-1), WRITE SHALL move to DONE; otherwise it moves to SCAN.
REQ-020 Latency per window SHALL be exactly KERNEL_DIM^2+2 cycles.
REQ-021 Total latency from the compute-sampling edge to output_valid=1 SHALL be N*INPUT_DIM^2 + N*OUTPUT_DIM^2*(K^2+2) + 1 cycles.
REQ-022 Input positions not covered by any window (INPUT_DIM not divisible by K) SHALL read +0.0.
REQ-023 DONE: output_valid=1, busy=0; compute=1 SHALL clear output_valid and move to CLEAR on the same edge.
REQ-024 While busy, act_write and grad_write SHALL be ignored, and compute SHALL be ignored.
REQ-025 In IDLE/DONE, external writes SHALL be accepted; if an external write and compute occur on the same edge, the write SHALL land first.
REQ-026 read_data SHALL be valid one cycle after read_index in any state; during busy its content is unspecified.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, busy=0, output_valid=0, and all counters, best and argmax to 0/NONE.
REQ-028 Memory contents SHALL NOT be cleared by reset; a reset mid-operation abandons the pass, and the next compute reruns it fully.

Structure
REQ-029 Package max_pool_pkg SHALL hold the state enum, the NONE argmax encoding, the binary64 greater-than function, and the index-field constants (ENTRY=2, Y=1, X=0).
REQ-030 The three memories (activation, upstream gradient, result) SHALL each be an instance of act_memory.
REQ-031 The result memory write port SHALL be muxed between CLEAR and WRITE.
REQ-032 No new sub-module SHALL be introduced.

Verification
REQ-033 N=1, D=4, K=2, activations 1..16 raster, gradients {10,20,30,40}: output_valid after exactly 41 cycles; result at (1,1)=10, (1,3)=20, (3,1)=30, (3,3)=40; other 12 locations 0.0.
REQ-034 Window {2.0, 5.0, 5.0, 1.0}, gradient 7.0: only k=1 receives 7.0; the k=2 location reads 0.0 (tie rule).
REQ-035 Window {-1.0, -2.0, -0.0, -3.0}, gradient 9.0: all four locations read 0.0 (discard rule).
REQ-036 D=5, K=2: row 4 and column 4 read 0.0; stale 3.0 preloaded there from a prior pass is also cleared to 0.0.
REQ-037 rst_n pulsed low mid-SCAN: output_valid and busy go 0 immediately, without waiting for clk; a following compute produces correct results, identical to REQ-033.
REQ-038 act_write of 99.0 while busy leaves the activation memory unchanged; compute asserted in DONE drops output_valid on the next edge and repeats an identical pass.
